alu_ctrl: RTL and testbench

Operand sequencer and write-back stage wrapped around the ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `a`/`b`/`mode` inputs, captures the result and overflow, writes the result back, and maintains status flags. It sits directly upstream and downstream of the ALU; the ALU is instantiated beside it at top level, not inside it.

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_ctrl_regfile.sv | 40 ++++
 rtl/alu_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Definitions shared by the ALU and its operand sequencer: opcodes, ALU mode
// encodings and the write-back flag bundle.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LDI = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  localparam logic ALU_MODE_ADD = 1'b0;
  localparam logic ALU_MODE_SUB = 1'b1;

  typedef struct packed {
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage : alu_ctrl_pkg

// File: rtl/alu_ctrl_regfile.sv
// Register file for alu_ctrl: three combinational read ports, one synchronous
// write port, r0 hardwired to zero.
module alu_ctrl_regfile #(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 8,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [REG_AW-1:0]    waddr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [REG_AW-1:0]    rs1_addr_i,
  output logic [WORD_SIZE-1:0] rs1_data_o,
  input  logic [REG_AW-1:0]    rs2_addr_i,
  output logic [WORD_SIZE-1:0] rs2_data_o,
  input  logic [REG_AW-1:0]    dbg_addr_i,
  output logic [WORD_SIZE-1:0] dbg_data_o
);

  logic [WORD_SIZE-1:0] mem_q [NUM_REGS];

  // NOTE: register files are normally left unreset; here every register must
  // read zero after reset, so the whole array is cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on every read port regardless of array contents.
  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : mem_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : mem_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule : alu_ctrl_regfile

// File: rtl/alu_ctrl.sv
// Operand sequencer and write-back stage around an external ALU: accepts one
// instruction per three cycles, feeds the ALU, writes back and keeps flags.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 8,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [1:0]           instr_op,
  input  logic [REG_AW-1:0]    instr_rd,
  input  logic [REG_AW-1:0]    instr_rs1,
  input  logic [REG_AW-1:0]    instr_rs2,
  input  logic [WORD_SIZE-1:0] instr_imm,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic                 alu_mode,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic                 alu_ovf,
  output logic                 done,
  output logic                 flag_ovf,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic                 sticky_ovf,
  input  logic                 clear_sticky,
  input  logic [REG_AW-1:0]    dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  state_e               state_q;
  op_e                  op_q;
  logic [REG_AW-1:0]    rd_q;
  logic [WORD_SIZE-1:0] imm_q;
  logic [WORD_SIZE-1:0] opa_q;
  logic [WORD_SIZE-1:0] opb_q;
  logic                 done_q;
  flags_t               flags_q, flags_d;
  logic                 sticky_q, sticky_d;

  logic                 exec;
  logic                 is_arith;
  logic                 rf_we;
  logic [WORD_SIZE-1:0] wb_value;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;

  alu_ctrl_regfile #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (wb_value),
    .rs1_addr_i (instr_rs1),
    .rs1_data_o (rs1_data),
    .rs2_addr_i (instr_rs2),
    .rs2_data_o (rs2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    exec     = (state_q == ST_EXEC);
    is_arith = op_is_arith(op_q);
    wb_value = (op_q == OP_LDI) ? imm_q : alu_c;
    rf_we    = exec && (op_q != OP_NOP);

    flags_d = flags_q;
    if (rf_we) begin
      flags_d.ovf  = is_arith && alu_ovf;
      flags_d.zero = (wb_value == '0);
      flags_d.neg  = wb_value[WORD_SIZE-1];
    end

    // Set beats clear when both land on the same edge.
    sticky_d = sticky_q;
    if (clear_sticky) begin
      sticky_d = 1'b0;
    end
    if (exec && is_arith && alu_ovf) begin
      sticky_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      done_q   <= 1'b0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= op_e'(instr_op);
            rd_q    <= instr_rd;
            imm_q   <= instr_imm;
            opa_q   <= rs1_data;
            opb_q   <= rs2_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          done_q  <= 1'b1;
          state_q <= ST_WB;
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand registers only change on accept, so the ALU inputs hold between
  // instructions.
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_mode    = (exec && (op_q == OP_SUB)) ? ALU_MODE_SUB : ALU_MODE_ADD;
  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign done        = done_q;
  assign flag_ovf    = flags_q.ovf;
  assign flag_zero   = flags_q.zero;
  assign flag_neg    = flags_q.neg;
  assign sticky_ovf  = sticky_q;

endmodule : alu_ctrl

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: a table of instructions with hand-computed
// results, plus sequences for sticky clearing, throughput and mid-op reset.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [W-1:0]  instr_imm;
  logic [W-1:0]  alu_a, alu_b, alu_c;
  logic          alu_mode, alu_ovf;
  logic          done, flag_ovf, flag_zero, flag_neg, sticky_ovf;
  logic          clear_sticky;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  always #5 clk = ~clk;

  // Reference ALU standing beside the block: wrapping add/sub with signed overflow.
  always_comb begin
    alu_c = (alu_mode == ALU_MODE_SUB) ? alu_a - alu_b : alu_a + alu_b;
    if (alu_mode == ALU_MODE_SUB)
      alu_ovf = (alu_a[W-1] != alu_b[W-1]) && (alu_c[W-1] != alu_a[W-1]);
    else
      alu_ovf = (alu_a[W-1] == alu_b[W-1]) && (alu_c[W-1] != alu_a[W-1]);
  end

  alu_ctrl #(.WORD_SIZE(W), .NUM_REGS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm    (instr_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_mode     (alu_mode),
    .alu_c        (alu_c),
    .alu_ovf      (alu_ovf),
    .done         (done),
    .flag_ovf     (flag_ovf),
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg),
    .sticky_ovf   (sticky_ovf),
    .clear_sticky (clear_sticky),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  typedef struct {
    op_e           op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [W-1:0]  imm;
    logic [W-1:0]  exp_a, exp_b;
    logic          exp_mode;
    logic [W-1:0]  exp_val;
    logic          exp_ovf, exp_zero, exp_neg, exp_sticky;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input op_e op, input int rd, input int rs1, input int rs2,
                              input int imm, input int a, input int b, input int mode,
                              input int val, input int ovf, input int z, input int n,
                              input int s);
    vec_t v;
    v.op = op; v.rd = AW'(rd); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2);
    v.imm = W'(imm); v.exp_a = W'(a); v.exp_b = W'(b); v.exp_mode = 1'(mode);
    v.exp_val = W'(val); v.exp_ovf = 1'(ovf); v.exp_zero = 1'(z);
    v.exp_neg = 1'(n); v.exp_sticky = 1'(s);
    return v;
  endfunction

  // Issues one instruction and checks EXEC, write-back and return-to-idle cycles.
  task automatic run_vec(input vec_t v, input bit clr_at_e1, input string tag);
    int waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "/ready_before"}, 32'(instr_ready), 32'd1);
    if (!instr_ready) return;
    instr_op = v.op; instr_rd = v.rd; instr_rs1 = v.rs1; instr_rs2 = v.rs2;
    instr_imm = v.imm; dbg_addr = v.rd; instr_valid = 1'b1;
    @(posedge clk); #1;
    // Fields are garbage after the handshake; only the latched copies matter.
    instr_valid = 1'b0;
    instr_op = 2'($urandom_range(0, 3));
    instr_rd = AW'($urandom); instr_rs1 = AW'($urandom); instr_rs2 = AW'($urandom);
    instr_imm = ~v.imm;
    if (clr_at_e1) clear_sticky = 1'b1;
    @(negedge clk);
    check({tag, "/exec_done"},  32'(done),     32'd0);
    check({tag, "/exec_ready"}, 32'(instr_ready), 32'd0);
    check({tag, "/alu_a"},      32'(alu_a),    32'(v.exp_a));
    check({tag, "/alu_b"},      32'(alu_b),    32'(v.exp_b));
    check({tag, "/alu_mode"},   32'(alu_mode), 32'(v.exp_mode));
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    @(negedge clk);
    check({tag, "/wb_done"},    32'(done),       32'd1);
    check({tag, "/wb_ready"},   32'(instr_ready), 32'd0);
    check({tag, "/wb_value"},   32'(dbg_data),   32'(v.exp_val));
    check({tag, "/flag_ovf"},   32'(flag_ovf),   32'(v.exp_ovf));
    check({tag, "/flag_zero"},  32'(flag_zero),  32'(v.exp_zero));
    check({tag, "/flag_neg"},   32'(flag_neg),   32'(v.exp_neg));
    check({tag, "/sticky"},     32'(sticky_ovf), 32'(v.exp_sticky));
    check({tag, "/wb_mode"},    32'(alu_mode),   32'd0);
    check({tag, "/wb_a_hold"},  32'(alu_a),      32'(v.exp_a));
    @(posedge clk);
    @(negedge clk);
    check({tag, "/idle_done"},  32'(done),        32'd0);
    check({tag, "/idle_ready"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, dn;
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_imm = '0; clear_sticky = 1'b0; dbg_addr = '0;

    //              op      rd rs1 rs2 imm  a    b    m  val   ovf z n s
    vecs[0]  = mk(OP_LDI, 1, 0, 0, 100, 0,   0,   0, 100,  0, 0, 0, 0);
    vecs[1]  = mk(OP_LDI, 2, 0, 0, 27,  0,   0,   0, 27,   0, 0, 0, 0);
    vecs[2]  = mk(OP_ADD, 3, 1, 2, 0,   100, 27,  0, 127,  0, 0, 0, 0);
    vecs[3]  = mk(OP_LDI, 4, 0, 0, 1,   0,   0,   0, 1,    0, 0, 0, 0);
    vecs[4]  = mk(OP_ADD, 5, 3, 4, 0,   127, 1,   0, 8'h80, 1, 0, 1, 1);
    vecs[5]  = mk(OP_SUB, 6, 1, 1, 0,   100, 100, 1, 0,    0, 1, 0, 1);
    vecs[6]  = mk(OP_NOP, 3, 1, 2, 0,   100, 27,  0, 127,  0, 1, 0, 1);
    vecs[7]  = mk(OP_LDI, 0, 0, 0, 55,  0,   0,   0, 0,    0, 0, 0, 1);
    vecs[8]  = mk(OP_SUB, 7, 2, 1, 0,   27,  100, 1, 8'hB7, 0, 0, 1, 1);
    vecs[9]  = mk(OP_SUB, 6, 5, 2, 0,   128, 27,  1, 8'h65, 1, 0, 0, 1);
    vecs[10] = mk(OP_ADD, 0, 5, 5, 0,   128, 128, 0, 0,    1, 1, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/ready",  32'(instr_ready), 32'd0);
    check("rst/done",   32'(done),        32'd0);
    check("rst/flags",  32'({flag_ovf, flag_zero, flag_neg}), 32'd0);
    check("rst/sticky", 32'(sticky_ovf),  32'd0);
    check("rst/alu_ab", 32'({alu_a, alu_b}), 32'd0);
    check("rst/mode",   32'(alu_mode),    32'd0);
    for (int i = 0; i < N; i++) begin
      dbg_addr = AW'(i);
      #1;
      check($sformatf("rst/r%0d", i), 32'(dbg_data), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst/ready_after", 32'(instr_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Clear with no write-back in flight.
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    @(negedge clk);
    check("clr/sticky",   32'(sticky_ovf), 32'd0);
    check("clr/flag_ovf", 32'(flag_ovf),   32'd1);

    // Clear on the same edge as an overflowing write-back, then without overflow.
    run_vec(mk(OP_ADD, 7, 5, 5, 0, 128, 128, 0, 0, 1, 1, 0, 1), 1'b1, "clr_vs_ovf");
    run_vec(mk(OP_LDI, 7, 0, 0, 5, 0, 0, 0, 5, 0, 0, 0, 0), 1'b1, "clr_ldi");

    // Throughput: four ADD r1 = r1 + r2 issued with instr_valid held high.
    run_vec(mk(OP_LDI, 1, 0, 0, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0, 0), 1'b0, "tp_ld1");
    run_vec(mk(OP_LDI, 2, 0, 0, 3, 0, 0, 0, 3, 0, 0, 0, 0), 1'b0, "tp_ld2");
    instr_op = OP_ADD; instr_rd = 3'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    instr_valid = 1'b1; dbg_addr = 3'd1;
    acc = 0; dn = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      check($sformatf("tp/ready_c%0d", cyc), 32'(instr_ready), 32'(cyc % 3 == 0));
      check($sformatf("tp/done_c%0d", cyc),  32'(done),        32'(cyc % 3 == 2));
      if (instr_ready) acc++;
      if (done) dn++;
      @(posedge clk); #1;
      if (acc == 4) instr_valid = 1'b0;
      @(negedge clk);
    end
    check("tp/accepts", 32'(acc), 32'd4);
    check("tp/dones",   32'(dn),  32'd4);
    check("tp/r1",      32'(dbg_data), 32'h1C);
    check("tp/flags",   32'({flag_ovf, flag_zero, flag_neg, sticky_ovf}), 32'd0);

    // Reset landing on the EXEC->WB edge suppresses write-back and done.
    run_vec(mk(OP_ADD, 6, 5, 5, 0, 128, 128, 0, 0, 1, 1, 0, 1), 1'b0, "pre_rst");
    instr_op = OP_ADD; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    dbg_addr = 3'd7; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mrst/exec_ready", 32'(instr_ready), 32'd0);
    check("mrst/exec_done",  32'(done),        32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mrst/done",   32'(done),        32'd0);
    check("mrst/ready",  32'(instr_ready), 32'd0);
    check("mrst/flags",  32'({flag_ovf, flag_zero, flag_neg}), 32'd0);
    check("mrst/sticky", 32'(sticky_ovf),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst/ready_after", 32'(instr_ready), 32'd1);
    check("mrst/done_after",  32'(done),        32'd0);
    check("mrst/r7",          32'(dbg_data),    32'd0);
    dbg_addr = 3'd1;
    #1;
    check("mrst/r1", 32'(dbg_data), 32'd0);
    run_vec(mk(OP_LDI, 3, 0, 0, 9, 0, 0, 0, 9, 0, 0, 0, 0), 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_ctrl
